// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared multi-cycle divider for the EXE stage.
// Latches the request operands, issues a one-cycle start pulse, waits for the
// completion pulse and holds the selected quotient/remainder until MEM accepts
// it. A one-entry result cache lets a div/mod pair on identical operands
// complete without a second divider pass. Flushes abort the op; a flush while
// the divider is running drains the in-flight result into the cache.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/signed/sel_quot   EXE request; held until handshake or flush
//   req_x, req_y                dividend, divisor
//   flush                       cancel current op
//   out_ready                   MEM allowin
//   resp_valid, resp_result     result handshake towards MEM
//   div_start                   one-cycle issue pulse (suppressed by flush)
//   div_signed, div_x, div_y    operands to divider, stable while it runs
//   div_done, div_s, div_r      completion pulse with quotient/remainder
//   busy                        controller not idle
//   perf_issue_cnt/hit_cnt      saturating issue / cache-hit counters
module div_issue_ctrl #(
  parameter int unsigned W        = 32,
  parameter int unsigned CACHE_EN = 1,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_signed,
  input  logic              req_sel_quot,
  input  logic [W-1:0]      req_x,
  input  logic [W-1:0]      req_y,
  input  logic              flush,
  input  logic              out_ready,
  output logic              resp_valid,
  output logic [W-1:0]      resp_result,
  output logic              div_start,
  output logic              div_signed,
  output logic [W-1:0]      div_x,
  output logic [W-1:0]      div_y,
  input  logic              div_done,
  input  logic [W-1:0]      div_s,
  input  logic [W-1:0]      div_r,
  output logic              busy,
  output logic [PERF_W-1:0] perf_issue_cnt,
  output logic [PERF_W-1:0] perf_hit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           sel_quot;
  logic           cache_valid;
  logic           cache_signed;
  logic [W-1:0]   cache_x;
  logic [W-1:0]   cache_y;
  logic [W-1:0]   cache_q;
  logic [W-1:0]   cache_r;

  logic           hit;
  logic           accept;
  logic           take_hit;
  logic           issue;
  logic           capture;
  logic           load_div_res;

  // Cache lookup on the live request; the key is {signed, x, y}
  assign hit = (CACHE_EN != 0) && cache_valid && (req_signed == cache_signed)
               && (req_x == cache_x) && (req_y == cache_y);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    take_hit     = 1'b0;
    issue        = 1'b0;
    capture      = 1'b0;
    load_div_res = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          accept = 1'b1;
          if (hit) begin
            take_hit  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_done) begin
          capture = 1'b1;
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            load_div_res = 1'b1;
            state_nxt    = S_HOLD;
          end
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush || out_ready) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // In-flight result still belongs to the latched key, so keep it
        if (div_done) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Start must be cancellable by a same-cycle flush, so it is decoded live
  assign div_start  = issue;
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_HOLD);

  // Operand latch, result register and cache
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_signed   <= 1'b0;
      div_x        <= '0;
      div_y        <= '0;
      sel_quot     <= 1'b0;
      resp_result  <= '0;
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_x      <= '0;
      cache_y      <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else begin
      if (accept) begin
        div_signed <= req_signed;
        div_x      <= req_x;
        div_y      <= req_y;
        sel_quot   <= req_sel_quot;
      end
      if (take_hit) begin
        resp_result <= req_sel_quot ? cache_q : cache_r;
      end else if (load_div_res) begin
        resp_result <= sel_quot ? div_s : div_r;
      end
      if (capture) begin
        cache_valid  <= (CACHE_EN != 0);
        cache_signed <= div_signed;
        cache_x      <= div_x;
        cache_y      <= div_y;
        cache_q      <= div_s;
        cache_r      <= div_r;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_issue_cnt <= '0;
      perf_hit_cnt   <= '0;
    end else begin
      if (issue && (perf_issue_cnt != '1)) perf_issue_cnt <= perf_issue_cnt + PERF_W'(1);
      if (take_hit && (perf_hit_cnt != '1)) perf_hit_cnt <= perf_hit_cnt + PERF_W'(1);
    end
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the shared multi-cycle divider on behalf of the EXE stage.
- Latches operands and issues a one-cycle start pulse, waits for completion, then holds the result until MEM accepts it.
- Handles pipeline flushes (branch or exception/ertn) while the divider is busy.
- Keeps a one-entry quotient/remainder cache so a div/mod pair on identical operands completes without a second divider pass.

Parameters:
- W, 32, operand/result width
- CACHE_EN, 1, enable the one-entry result cache (0: every request issues)
- PERF_W, 32, width of the saturating performance counters

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  EXE holds a valid div/mod op; held stable until handshake or flush
- req_signed  in  1  signed operation
- req_sel_quot  in  1  1: return quotient, 0: return remainder
- req_x  in  W  dividend
- req_y  in  W  divisor
- flush  in  1  cancel current op (branch taken or exception/ertn)
- out_ready  in  1  MEM allowin
- resp_valid  out  1  result available (EXE ready_go)
- resp_result  out  W  selected quotient/remainder
- div_start  out  1  one-cycle issue pulse to divider
- div_signed  out  1  registered operand to divider
- div_x  out  W  registered operand to divider
- div_y  out  W  registered operand to divider
- div_done  in  1  one-cycle completion pulse from divider
- div_s  in  W  quotient, valid with div_done
- div_r  in  W  remainder, valid with div_done
- busy  out  1  state != IDLE
- perf_issue_cnt  out  PERF_W  divider issues, saturating
- perf_hit_cnt  out  PERF_W  cache hits, saturating

Behaviour:
- Reset (async, resetn=0): state=IDLE, cache_valid=0, all outputs 0, counters 0. Reset mid-operation returns to IDLE immediately. Any divider result arriving after reset deasserts is ignored (div_done outside WAIT/DRAIN is dropped).
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN.
- IDLE:
  - On req_valid & ~flush, latch {signed, sel_quot, x, y}.
  - hit = CACHE_EN & cache_valid & {req_signed, req_x, req_y} == cached key.
  - hit -> HOLD, result taken from cache, perf_hit_cnt+1.
  - miss -> ISSUE.
  - Request and flush in the same cycle: nothing accepted.
- ISSUE:
  - div_start=1 for exactly this cycle; div_x/div_y/div_signed are driven from latched registers and remain stable until leaving WAIT.
  - perf_issue_cnt+1; -> WAIT.
  - flush: div_start is suppressed, no count, -> IDLE.
- WAIT: on div_done, capture div_s and div_r into the cache with key {signed, x, y}, set cache_valid, -> HOLD.
  - flush without div_done -> DRAIN.
  - flush with div_done -> cache is updated, -> IDLE.
- HOLD:
  - resp_valid=1; resp_result = sel_quot ? cached quotient : cached remainder.
  - Result is held stable under backpressure.
  - out_ready -> IDLE. The next request is evaluated the following cycle, so there is one bubble between back-to-back ops.
  - flush -> IDLE with no response delivered; the cache is kept.
- DRAIN: busy=1, resp_valid=0. New requests are not accepted. On div_done, update the cache (the result is valid for the latched key), -> IDLE.
- resp_valid is asserted only in HOLD. Latency:
  - cache hit: resp_valid 1 cycle after acceptance.
  - miss: ISSUE + divider latency + 1.
- Divide by zero and overflow (INT_MIN/-1) are not special-cased. Divider outputs pass through and are cacheable.
- Counters saturate at all-ones.
- CACHE_EN=0: cache_valid is tied to 0 and perf_hit_cnt stays 0.

Test Plan:
- Signed div, x=100, y=7, sel_quot=1, divider latency 33 -> one div_start pulse, resp_valid from cycle 35 after acceptance, result 14. Hold out_ready=0 for 3 cycles -> result stable. out_ready=1 -> IDLE.
- Follow-up mod, x=100, y=7, signed, sel_quot=0 -> no div_start, resp_valid next cycle, result 2, perf_hit_cnt=1. The same operands with req_signed=0 -> miss, div_start issued.
- Signed x=-7, y=2 -> quot -3 (0xFFFFFFFD) via div; a subsequent mod hit returns -1 (0xFFFFFFFF).
- Flush 5 cycles into WAIT -> DRAIN, busy=1. A new req_valid is ignored until div_done. Then IDLE, and the new request issues next cycle. The cache holds the drained operands.
- Flush during ISSUE -> div_start=0 that cycle, perf_issue_cnt unchanged. Flush in HOLD -> resp_valid drops next cycle.
- resetn low during WAIT -> all outputs 0 asynchronously. A stale div_done after release is ignored, and the cache stays invalid.
